// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder.
package mem_pkg;

  typedef enum logic [1:0] {
    MS_BYTE = 2'd0,
    MS_HALF = 2'd1,
    MS_WORD = 2'd2,
    MS_BAD  = 2'd3
  } MemSize;

  typedef enum logic [1:0] {
    MST_IDLE  = 2'd0,
    MST_ACC_A = 2'd1,
    MST_ACC_B = 2'd2,
    MST_RESP  = 2'd3
  } MemState;

  localparam logic [2:0] NBYTES_BYTE = 3'd1;
  localparam logic [2:0] NBYTES_HALF = 3'd2;
  localparam logic [2:0] NBYTES_WORD = 3'd4;

  // Byte count of an access; the illegal size counts as zero bytes.
  function automatic logic [2:0] size_nbytes(MemSize size);
    logic [2:0] n;
    case (size)
      MS_BYTE: n = NBYTES_BYTE;
      MS_HALF: n = NBYTES_HALF;
      MS_WORD: n = NBYTES_WORD;
      default: n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering between a right-justified request and up to two RAM words.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  i_off,
  input  MemSize      i_size,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_rdata_a,
  input  logic [31:0] i_rdata_b,
  output logic [3:0]  o_be_a,
  output logic [3:0]  o_be_b,
  output logic [31:0] o_wdata_a,
  output logic [31:0] o_wdata_b,
  output logic [31:0] o_rdata,
  output logic        o_split
);

  logic [3:0]  w_mask;
  logic [7:0]  w_be_full;
  logic [63:0] w_wdata_full;
  logic [31:0] w_rmask;
  logic [5:0]  w_shift;

  // Lane mask for the access width, right-justified.
  always_comb begin
    w_mask = 4'b0000;
    case (i_size)
      MS_BYTE: w_mask = 4'b0001;
      MS_HALF: w_mask = 4'b0011;
      MS_WORD: w_mask = 4'b1111;
      default: w_mask = 4'b0000;
    endcase
  end

  // Expand the lane mask to a bit mask for zero-extending read data.
  always_comb begin
    w_rmask = '0;
    for (int l = 0; l < 4; l++) begin
      w_rmask[8*l +: 8] = {8{w_mask[l]}};
    end
  end

  assign w_shift      = {1'b0, i_off, 3'b000};
  // Lanes spilling past byte 3 land in the upper half and belong to word B.
  assign w_be_full    = {4'b0000, w_mask} << i_off;
  assign w_wdata_full = {32'h0, i_wdata} << w_shift;

  assign o_be_a    = w_be_full[3:0];
  assign o_be_b    = w_be_full[7:4];
  assign o_wdata_a = w_wdata_full[31:0];
  assign o_wdata_b = w_wdata_full[63:32];
  assign o_split   = |w_be_full[7:4];
  assign o_rdata   = 32'({i_rdata_b, i_rdata_a} >> w_shift) & w_rmask;

endmodule

// File: rtl/mem_responder.sv
// Responder side of the CPU memory interface backed by a word-wide RAM.
// Unaligned accesses crossing a word boundary take two RAM cycles.
module mem_responder
  import mem_pkg::*;
#(
  parameter int unsigned WORDS     = 16384,
  parameter string       INIT_FILE = "../ram/ram.bits"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic [31:0] i_req_addr,
  input  logic [1:0]  i_req_size,
  input  logic        i_req_we,
  input  logic [31:0] i_req_wdata,
  output logic        o_rsp_valid,
  output logic [31:0] o_rsp_rdata,
  output logic        o_rsp_err
);

  localparam int unsigned AW       = $clog2(WORDS);
  localparam logic [32:0] LIMIT_B  = 33'(WORDS) << 2;

  logic [31:0] r_mem [WORDS];

  MemState     r_state, w_state_d;
  logic [AW-1:0] r_idx;
  logic [1:0]  r_off;
  MemSize      r_size;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        r_err;
  logic [31:0] r_rdata_a, r_rdata_b;

  logic        w_accept;
  MemSize      w_req_size;
  logic [32:0] w_last;
  logic        w_req_err;
  logic [3:0]  w_be_a, w_be_b, w_mem_be;
  logic [31:0] w_wdata_a, w_wdata_b, w_mem_wdata, w_rdata;
  logic        w_split;
  logic        w_mem_en;
  logic [AW-1:0] w_mem_idx;

  // Range check on the last byte touched; no wrap-around is allowed.
  assign w_req_size = MemSize'(i_req_size);
  assign w_last     = {1'b0, i_req_addr} + 33'(size_nbytes(w_req_size)) - 33'd1;
  assign w_req_err  = (w_req_size == MS_BAD) || (w_last >= LIMIT_B);

  assign o_req_ready = (r_state == MST_IDLE) && !i_rst;
  assign w_accept    = i_req_valid && o_req_ready;

  mem_lane_align u_align (
    .i_off     (r_off),
    .i_size    (r_size),
    .i_wdata   (r_wdata),
    .i_rdata_a (r_rdata_a),
    .i_rdata_b (r_rdata_b),
    .o_be_a    (w_be_a),
    .o_be_b    (w_be_b),
    .o_wdata_a (w_wdata_a),
    .o_wdata_b (w_wdata_b),
    .o_rdata   (w_rdata),
    .o_split   (w_split)
  );

  // Next-state logic.
  always_comb begin
    w_state_d = r_state;
    case (r_state)
      MST_IDLE:  if (w_accept) w_state_d = w_req_err ? MST_RESP : MST_ACC_A;
      MST_ACC_A: w_state_d = w_split ? MST_ACC_B : MST_RESP;
      MST_ACC_B: w_state_d = MST_RESP;
      MST_RESP:  w_state_d = MST_IDLE;
      default:   w_state_d = MST_IDLE;
    endcase
  end

  // State register and request latch; reset aborts any access in flight.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= MST_IDLE;
      r_idx   <= '0;
      r_off   <= '0;
      r_size  <= MS_BYTE;
      r_we    <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_d;
      if (w_accept) begin
        r_idx   <= i_req_addr[AW+1:2];
        r_off   <= i_req_addr[1:0];
        r_size  <= w_req_size;
        r_we    <= i_req_we;
        r_wdata <= i_req_wdata;
        r_err   <= w_req_err;
      end
    end
  end

  assign w_mem_en    = (r_state == MST_ACC_A) || (r_state == MST_ACC_B);
  assign w_mem_idx   = (r_state == MST_ACC_B) ? r_idx + AW'(1) : r_idx;
  assign w_mem_be    = (r_state == MST_ACC_B) ? w_be_b : w_be_a;
  assign w_mem_wdata = (r_state == MST_ACC_B) ? w_wdata_b : w_wdata_a;

  // RAM port: lane-masked writes, or full-word capture into the holding registers.
  always_ff @(posedge i_clk) begin
    if (w_mem_en) begin
      if (r_we) begin
        for (int l = 0; l < 4; l++) begin
          if (w_mem_be[l]) r_mem[w_mem_idx][8*l +: 8] <= w_mem_wdata[8*l +: 8];
        end
      end else if (r_state == MST_ACC_A) begin
        r_rdata_a <= r_mem[w_mem_idx];
      end else begin
        r_rdata_b <= r_mem[w_mem_idx];
      end
    end
  end

  assign o_rsp_valid = (r_state == MST_RESP);
  assign o_rsp_err   = o_rsp_valid && r_err;
  assign o_rsp_rdata = (o_rsp_valid && !r_we && !r_err) ? w_rdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus pushes expectations, a monitor pops them.
module tb_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [1:0]  req_size = '0;
  logic        req_we = 1'b0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  typedef struct {
    int          cyc;
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;

  mem_responder #(
    .WORDS     (16384),
    .INIT_FILE ("")
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (req_valid),
    .o_req_ready (req_ready),
    .i_req_addr  (req_addr),
    .i_req_size  (req_size),
    .i_req_we    (req_we),
    .i_req_wdata (req_wdata),
    .o_rsp_valid (rsp_valid),
    .o_rsp_rdata (rsp_rdata),
    .o_rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %08h, want %08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rsp_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_rsp: got rdata=%08h err=%0b at cycle %0d, want no response",
                 rsp_rdata, rsp_err, cyc);
      end else begin
        e = sb.pop_front();
        check({e.name, "/cycle"}, 32'(cyc), 32'(e.cyc));
        check({e.name, "/rdata"}, rsp_rdata, e.rdata);
        check({e.name, "/err"}, 32'(rsp_err), 32'(e.err));
      end
    end
  end

  task automatic wait_ready(input string name, output logic ok);
    int waited = 0;
    @(negedge clk);
    while (!req_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    ok = req_ready;
    if (!ok) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s/ready_timeout: got ready=0, want ready=1 within 50 cycles", name);
    end
  endtask

  task automatic issue(input string name, input logic [31:0] addr, input logic [1:0] size,
                       input logic we, input logic [31:0] wdata, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat);
    logic ok;
    wait_ready(name, ok);
    if (ok) begin
      req_valid = 1'b1;
      req_addr  = addr;
      req_size  = size;
      req_we    = we;
      req_wdata = wdata;
      sb.push_back('{cyc + lat, exp_rd, exp_err, name});
      @(negedge clk);
      // Scramble inputs after accept; the latched request must be used.
      req_valid = 1'b0;
      req_addr  = $urandom;
      req_size  = 2'($urandom_range(0, 3));
      req_we    = 1'($urandom_range(0, 1));
      req_wdata = $urandom;
    end
  endtask

  task automatic drain(input string name);
    int waited = 0;
    while (sb.size() != 0 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (sb.size() != 0) begin
      n_vec++;
      n_bad++;
      $display("FAIL %s/drain: got %0d pending responses, want 0", name, sb.size());
      sb.delete();
    end
  endtask

  initial begin
    logic ok;
    #1 rst = 1'b1;
    #2;
    check("reset/ready", 32'(req_ready), 32'd0);
    check("reset/valid", 32'(rsp_valid), 32'd0);
    check("reset/rdata", rsp_rdata, 32'h0);
    check("reset/err", 32'(rsp_err), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1 check("release/ready", 32'(req_ready), 32'd1);

    // Aligned word and byte lanes
    issue("wr_w100",  32'h100, 2'd2, 1'b1, 32'hDEADBEEF, 32'h0,        1'b0, 2);
    issue("rd_w100",  32'h100, 2'd2, 1'b0, 32'h0,        32'hDEADBEEF, 1'b0, 2);
    issue("wr_b101",  32'h101, 2'd0, 1'b1, 32'hFFFFFF55, 32'h0,        1'b0, 2);
    issue("rd_w100b", 32'h100, 2'd2, 1'b0, 32'h0,        32'hDEAD55EF, 1'b0, 2);
    issue("rd_b103",  32'h103, 2'd0, 1'b0, 32'h0,        32'h000000DE, 1'b0, 2);

    // Split reads
    issue("wr_w100c", 32'h100, 2'd2, 1'b1, 32'h11223344, 32'h0,        1'b0, 2);
    issue("wr_w104",  32'h104, 2'd2, 1'b1, 32'hAABBCCDD, 32'h0,        1'b0, 2);
    issue("rd_h103",  32'h103, 2'd1, 1'b0, 32'h0,        32'h0000DD11, 1'b0, 3);
    issue("rd_w102",  32'h102, 2'd2, 1'b0, 32'h0,        32'hCCDD1122, 1'b0, 3);
    issue("rd_h100",  32'h100, 2'd1, 1'b0, 32'h0,        32'h00003344, 1'b0, 2);

    // Split write
    issue("wr_w102",  32'h102, 2'd2, 1'b1, 32'hCAFEF00D, 32'h0,        1'b0, 3);
    issue("rd_w100d", 32'h100, 2'd2, 1'b0, 32'h0,        32'hF00D3344, 1'b0, 2);
    issue("rd_w104b", 32'h104, 2'd2, 1'b0, 32'h0,        32'hAABBCAFE, 1'b0, 2);

    // Top-of-range boundary and errors
    issue("wr_w0",     32'h0,        2'd2, 1'b1, 32'h0BADF00D, 32'h0,        1'b0, 2);
    issue("wr_wfffc",  32'hFFFC,     2'd2, 1'b1, 32'h89ABCDEF, 32'h0,        1'b0, 2);
    issue("rd_hfffe",  32'hFFFE,     2'd1, 1'b0, 32'h0,        32'h000089AB, 1'b0, 2);
    issue("err_size3", 32'h0,        2'd3, 1'b0, 32'h0,        32'h0,        1'b1, 1);
    issue("err_wfffe", 32'hFFFE,     2'd2, 1'b1, 32'h12345678, 32'h0,        1'b1, 1);
    issue("rd_wfffc",  32'hFFFC,     2'd2, 1'b0, 32'h0,        32'h89ABCDEF, 1'b0, 2);
    issue("rd_w0",     32'h0,        2'd2, 1'b0, 32'h0,        32'h0BADF00D, 1'b0, 2);
    issue("err_b10000", 32'h10000,   2'd0, 1'b0, 32'h0,        32'h0,        1'b1, 1);

    // Reset during ACC_B of a split write: word A kept, word B untouched, no response
    issue("pre_w100", 32'h100, 2'd2, 1'b1, 32'h11223344, 32'h0, 1'b0, 2);
    issue("pre_w104", 32'h104, 2'd2, 1'b1, 32'hAABBCCDD, 32'h0, 1'b0, 2);
    drain("pre_reset");
    wait_ready("rst_split", ok);
    if (ok) begin
      req_valid = 1'b1;
      req_addr  = 32'h102;
      req_size  = 2'd2;
      req_we    = 1'b1;
      req_wdata = 32'hCAFEF00D;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
      #1 check("rst_split/ready_in_reset", 32'(req_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("rst_split/valid_in_reset", 32'(rsp_valid), 32'd0);
      rst = 1'b0;
      #1 check("rst_split/ready_after", 32'(req_ready), 32'd1);
    end
    issue("post_w100", 32'h100, 2'd2, 1'b0, 32'h0, 32'hF00D3344, 1'b0, 2);
    issue("post_w104", 32'h104, 2'd2, 1'b0, 32'h0, 32'hAABBCCDD, 1'b0, 2);
    drain("final");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, want finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
